maze_game_fsm: RTL
==================

MAZE_GAME_FSM -- requirements
Module: maze_game_fsm

Interface
REQ-001 Parameter MAP_W, default 30, maze columns (bits per map ROM word).
REQ-002 Parameter MAP_H, default 21, maze rows (map ROM depth).
REQ-003 Parameters START_X/START_Y, defaults 0/20, player spawn cell.
REQ-004 Parameters GOAL_X/GOAL_Y, defaults 29/0, exit cell.
REQ-005 Parameters SHOW_EASY/SHOW_MED/SHOW_HARD, defaults 1000000/500000/250000, map-visible cycles per difficulty; all SHALL be >= 1.
REQ-006 clk  in  1  system clock; all state changes on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 btn  in  4  one-cycle move pulses {up,down,left,right} = bits [3:0].
REQ-009 select  in  1  one-cycle confirm pulse.
REQ-010 rom_data  in  MAP_W  map ROM row word; bit x = 1 means wall; valid one cycle after rom_addr is driven.
REQ-011 rom_addr  out  5  map ROM row address.
REQ-012 game_state  out  4  one-hot {won,lost,in_game,in_menu} = bits [3:0].
REQ-013 menu_sel  out  3  one-hot {instructions,difficulty,start} = bits [2:0].
REQ-014 difficulty  out  3  one-hot {hard,medium,easy} = bits [2:0].
REQ-015 map_visible  out  1  high while the map is shown.
REQ-016 player_x / player_y  out  8 each  current player cell.
REQ-017 busy  out  1  high while a move check is outstanding.

Function
REQ-018 Internal FSM states: MENU, SHOW_MAP, PLAYING, CHK_ISSUE, CHK_WAIT, LOST, WON; game_state SHALL be in_menu in MENU, in_game in SHOW_MAP/PLAYING/CHK_*, lost in LOST, won in WON.
REQ-019 MENU: up/down SHALL rotate menu_sel start->difficulty->instructions->start (down) and the reverse (up), wrapping at both ends; left/right are ignored.
REQ-020 MENU, select with difficulty selected: difficulty SHALL rotate easy->medium->hard->easy; state stays MENU.
REQ-021 MENU, select with instructions selected: no state change.
REQ-022 MENU, select with start selected: load player to START, load countdown with SHOW_<difficulty>-1, go to SHOW_MAP.
REQ-023 SHOW_MAP: map_visible=1; countdown decrements each cycle; when countdown is 0 go to PLAYING on that edge, so map_visible is high for exactly SHOW_<difficulty> cycles; all btn pulses ignored.
REQ-024 PLAYING: on a btn pulse compute candidate cell; simultaneous bits resolve by priority up > down > left > right (only one move per pulse).
REQ-025 up = y-1, down = y+1, left = x-1, right = x+1; a candidate outside 0..MAP_W-1 / 0..MAP_H-1 SHALL be discarded with no ROM access and the state stays PLAYING.
REQ-026 In-range candidate: go to CHK_ISSUE, drive rom_addr = candidate y, busy=1.
REQ-027 CHK_ISSUE -> CHK_WAIT next cycle; in CHK_WAIT sample rom_data[candidate x].
REQ-028 Wall bit = 1: position unchanged, go to LOST.
REQ-029 Wall bit = 0: commit candidate to player_x/player_y; go to WON if candidate equals GOAL, else PLAYING; a move therefore completes 2 cycles after the pulse.
REQ-030 btn pulses arriving while busy=1 SHALL be dropped, not queued.
REQ-031 Outside CHK_*, rom_addr SHALL equal player_y.
REQ-032 LOST/WON: select returns to MENU with player at START and menu_sel = start; all other inputs ignored.
REQ-033 select is ignored in SHOW_MAP, PLAYING and CHK_* states.

Reset
REQ-034 While reset=1, regardless of clk: state MENU, game_state=0001, menu_sel=001, difficulty=001, map_visible=0, busy=0, player_x=START_X, player_y=START_Y, rom_addr=START_Y, countdown=0.
REQ-035 Reset asserted mid-countdown or mid-check SHALL abandon the operation with no position commit.

Verification (SHOW_EASY=4, SHOW_MED=3, SHOW_HARD=2, MAP 30x21, ROM model with 1-cycle latency)
REQ-036 Reset, select -> game_state=0010, map_visible high exactly 4 cycles, then PLAYING.
REQ-037 MENU: down, select, select, up, select -> difficulty=100, then map_visible high exactly 2 cycles.
REQ-038 At spawn (0,20): left pulse -> discarded, no ROM access; down pulse -> discarded (y=21 out of range); up with row 19 bit0=0 -> player=(0,19) two cycles later, busy high for 2 cycles.
REQ-039 Right pulse with rom row 20 bit1=1 -> game_state=0100, player stays (0,20); then select -> MENU, player=(0,20).
REQ-040 btn=1111 in PLAYING -> only the up move is performed; second pulse during busy -> dropped.
REQ-041 Player at (28,0), right with row 0 bit29=0 -> player=(29,0), game_state=1000; reset asserted during CHK_WAIT of another run -> immediately MENU, spawn position.

Source files
------------

// File: rtl/maze_game_fsm.sv
// Memory-maze game controller: menu navigation, timed map preview, and
// wall-checked player movement against an external 1-cycle-latency map ROM.
module maze_game_fsm #(
    parameter int MAP_W     = 30,
    parameter int MAP_H     = 21,
    parameter int START_X   = 0,
    parameter int START_Y   = 20,
    parameter int GOAL_X    = 29,
    parameter int GOAL_Y    = 0,
    parameter int SHOW_EASY = 1000000,
    parameter int SHOW_MED  = 500000,
    parameter int SHOW_HARD = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       btn,
    input  logic             select,
    input  logic [MAP_W-1:0] rom_data,
    output logic [4:0]       rom_addr,
    output logic [3:0]       game_state,
    output logic [2:0]       menu_sel,
    output logic [2:0]       difficulty,
    output logic             map_visible,
    output logic [7:0]       player_x,
    output logic [7:0]       player_y,
    output logic             busy
);

    localparam logic [2:0] S_MENU      = 3'd0;
    localparam logic [2:0] S_SHOW_MAP  = 3'd1;
    localparam logic [2:0] S_PLAYING   = 3'd2;
    localparam logic [2:0] S_CHK_ISSUE = 3'd3;
    localparam logic [2:0] S_CHK_WAIT  = 3'd4;
    localparam logic [2:0] S_LOST      = 3'd5;
    localparam logic [2:0] S_WON       = 3'd6;

    localparam logic [7:0] MAX_X   = 8'(MAP_W - 1);
    localparam logic [7:0] MAX_Y   = 8'(MAP_H - 1);
    localparam logic [7:0] SPAWN_X = 8'(START_X);
    localparam logic [7:0] SPAWN_Y = 8'(START_Y);

    logic [2:0]       state_q, state_d;
    logic [2:0]       menu_sel_q, menu_sel_d;
    logic [2:0]       difficulty_q, difficulty_d;
    logic [31:0]      countdown_q, countdown_d;
    logic [7:0]       player_x_q, player_x_d;
    logic [7:0]       player_y_q, player_y_d;
    logic [7:0]       cand_x_q, cand_x_d;
    logic [7:0]       cand_y_q, cand_y_d;
    logic [7:0]       mv_x, mv_y;
    logic             mv_ok;
    logic [31:0]      show_load;
    logic [MAP_W-1:0] rom_shift;
    logic             wall_bit;

    // Only the highest-priority pressed direction is considered; if it leaves the maze the pulse is discarded.
    always_comb begin
        mv_x  = player_x_q;
        mv_y  = player_y_q;
        mv_ok = 1'b0;
        if (btn[3]) begin
            if (player_y_q != 8'd0) begin
                mv_y  = player_y_q - 8'd1;
                mv_ok = 1'b1;
            end
        end else if (btn[2]) begin
            if (player_y_q < MAX_Y) begin
                mv_y  = player_y_q + 8'd1;
                mv_ok = 1'b1;
            end
        end else if (btn[1]) begin
            if (player_x_q != 8'd0) begin
                mv_x  = player_x_q - 8'd1;
                mv_ok = 1'b1;
            end
        end else if (btn[0]) begin
            if (player_x_q < MAX_X) begin
                mv_x  = player_x_q + 8'd1;
                mv_ok = 1'b1;
            end
        end
    end

    always_comb begin
        case (difficulty_q)
            3'b100:  show_load = 32'(SHOW_HARD - 1);
            3'b010:  show_load = 32'(SHOW_MED - 1);
            default: show_load = 32'(SHOW_EASY - 1);
        endcase
    end

    assign rom_shift = rom_data >> cand_x_q;
    assign wall_bit  = rom_shift[0];

    always_comb begin
        state_d      = state_q;
        menu_sel_d   = menu_sel_q;
        difficulty_d = difficulty_q;
        countdown_d  = countdown_q;
        player_x_d   = player_x_q;
        player_y_d   = player_y_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        case (state_q)
            S_MENU: begin
                if (btn[3]) begin
                    menu_sel_d = {menu_sel_q[0], menu_sel_q[2:1]};
                end else if (btn[2]) begin
                    menu_sel_d = {menu_sel_q[1:0], menu_sel_q[2]};
                end else if (select) begin
                    if (menu_sel_q[1]) begin
                        difficulty_d = {difficulty_q[1:0], difficulty_q[2]};
                    end else if (menu_sel_q[0]) begin
                        player_x_d  = SPAWN_X;
                        player_y_d  = SPAWN_Y;
                        countdown_d = show_load;
                        state_d     = S_SHOW_MAP;
                    end
                end
            end
            S_SHOW_MAP: begin
                if (countdown_q == 32'd0) begin
                    state_d = S_PLAYING;
                end else begin
                    countdown_d = countdown_q - 32'd1;
                end
            end
            S_PLAYING: begin
                if (mv_ok) begin
                    cand_x_d = mv_x;
                    cand_y_d = mv_y;
                    state_d  = S_CHK_ISSUE;
                end
            end
            S_CHK_ISSUE: state_d = S_CHK_WAIT;
            S_CHK_WAIT: begin
                if (wall_bit) begin
                    state_d = S_LOST;
                end else begin
                    player_x_d = cand_x_q;
                    player_y_d = cand_y_q;
                    if (cand_x_q == 8'(GOAL_X) && cand_y_q == 8'(GOAL_Y)) begin
                        state_d = S_WON;
                    end else begin
                        state_d = S_PLAYING;
                    end
                end
            end
            S_LOST, S_WON: begin
                if (select) begin
                    player_x_d = SPAWN_X;
                    player_y_d = SPAWN_Y;
                    menu_sel_d = 3'b001;
                    state_d    = S_MENU;
                end
            end
            default: state_d = S_MENU;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_MENU;
            menu_sel_q   <= 3'b001;
            difficulty_q <= 3'b001;
            countdown_q  <= 32'd0;
            player_x_q   <= SPAWN_X;
            player_y_q   <= SPAWN_Y;
            cand_x_q     <= SPAWN_X;
            cand_y_q     <= SPAWN_Y;
        end else begin
            state_q      <= state_d;
            menu_sel_q   <= menu_sel_d;
            difficulty_q <= difficulty_d;
            countdown_q  <= countdown_d;
            player_x_q   <= player_x_d;
            player_y_q   <= player_y_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
        end
    end

    always_comb begin
        case (state_q)
            S_MENU:  game_state = 4'b0001;
            S_LOST:  game_state = 4'b0100;
            S_WON:   game_state = 4'b1000;
            default: game_state = 4'b0010;
        endcase
    end

    assign busy        = (state_q == S_CHK_ISSUE) || (state_q == S_CHK_WAIT);
    assign rom_addr    = busy ? cand_y_q[4:0] : player_y_q[4:0];
    assign map_visible = (state_q == S_SHOW_MAP);
    assign menu_sel    = menu_sel_q;
    assign difficulty  = difficulty_q;
    assign player_x    = player_x_q;
    assign player_y    = player_y_q;

endmodule
